// File: rtl/tpu_pkg.sv
// Shared types and constants for the MAC-array operand feeders.
package tpu_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StFull, StStream} feeder_state_e;

  localparam int unsigned DefaultDim    = 8;
  localparam int unsigned DefaultBitsAb = 8;

  // Injection takes 2*DIM-1 cycles, then DIM-1 more to flush the far corner.
  function automatic int unsigned stream_len(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Row-load and skewed-lane bus between a tile source, the feeder and the MAC array edge.
interface systolic_skew_feeder_if #(
    parameter int unsigned DIM     = tpu_pkg::DefaultDim,
    parameter int unsigned BITS_AB = tpu_pkg::DefaultBitsAb
);
    logic                   row_valid;
    logic                   row_ready;
    logic [DIM*BITS_AB-1:0] row_data;
    logic                   start;
    logic [DIM*BITS_AB-1:0] lane_out;
    logic                   en_out;
    logic                   busy;
    logic                   done;

    modport master (
        output row_valid, row_data, start,
        input  row_ready, lane_out, en_out, busy, done
    );

    modport slave (
        input  row_valid, row_data, start,
        output row_ready, lane_out, en_out, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers one DIM x DIM operand tile row by row, then streams it into the systolic array
// with lane r delayed by r cycles.
module systolic_skew_feeder #(
    parameter int unsigned DIM     = tpu_pkg::DefaultDim,
    parameter int unsigned BITS_AB = tpu_pkg::DefaultBitsAb
) (
    input logic                  clk,
    input logic                  rst_n,
    systolic_skew_feeder_if.slave bus
);
    import tpu_pkg::*;

    localparam int unsigned StreamLen = stream_len(DIM);
    localparam int unsigned TW        = $clog2(StreamLen + 1);
    localparam int unsigned CW        = (DIM > 1) ? $clog2(DIM) : 1;

    feeder_state_e          state_q;
    logic [CW-1:0]          cnt_q;
    logic [TW-1:0]          t_q;
    logic [TW-1:0]          t_sel;
    logic [BITS_AB-1:0]     mem [DIM][DIM];
    logic [DIM*BITS_AB-1:0] lane_q, lane_d;
    logic                   en_q, busy_q, done_q;
    logic                   accept;

    // Gated with rst_n so the source sees no ready while reset is held.
    assign bus.row_ready = rst_n && ((state_q == StIdle) || (state_q == StLoad));
    assign accept        = bus.row_valid && bus.row_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < int'(DIM); k++) begin
                mem[cnt_q][k] <= bus.row_data[k*BITS_AB +: BITS_AB];
            end
        end
    end

    // Operands for the stream cycle being registered: t=0 on the launch edge, else t_q.
    always_comb begin
        lane_d = '0;
        t_sel  = (state_q == StFull) ? '0 : t_q;
        for (int r = 0; r < int'(DIM); r++) begin
            for (int k = 0; k < int'(DIM); k++) begin
                if (int'(t_sel) == r + k) begin
                    lane_d[r*BITS_AB +: BITS_AB] = mem[r][k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            t_q     <= '0;
            lane_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StLoad: begin
                    if (accept) begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= (cnt_q == CW'(DIM - 1)) ? StFull : StLoad;
                    end
                end
                StFull: begin
                    if (bus.start) begin
                        state_q <= StStream;
                        t_q     <= TW'(1);
                        lane_q  <= lane_d;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StStream: begin
                    if (t_q == TW'(StreamLen)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        t_q     <= '0;
                        lane_q  <= '0;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        lane_q <= lane_d;
                        t_q    <= t_q + TW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.lane_out = lane_q;
    assign bus.en_out   = en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: a DIM=3 instance and a DIM=2 instance.
module tb_systolic_skew_feeder;
    import tpu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DIM(3), .BITS_AB(8)) bus3 ();
    systolic_skew_feeder_if #(.DIM(2), .BITS_AB(8)) bus2 ();

    systolic_skew_feeder #(.DIM(3), .BITS_AB(8)) dut3 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus3.slave)
    );

    systolic_skew_feeder #(.DIM(2), .BITS_AB(8)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2.slave)
    );

    // Lane vectors packed {lane2, lane1, lane0}.
    logic [23:0] exp_a [7] = '{24'h000001, 24'h000402, 24'h070503, 24'h080600,
                               24'h090000, 24'h000000, 24'h000000};
    logic [23:0] exp_b [7] = '{24'h000021, 24'h003122, 24'h413223, 24'h423300,
                               24'h430000, 24'h000000, 24'h000000};
    logic [15:0] exp_s [4] = '{16'h0080, 16'hFF7F, 16'h0000, 16'h0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with row_ready high; returns at the negedge after the accept.
    task automatic load3(input logic [23:0] row);
        bus3.row_valid = 1'b1;
        bus3.row_data  = row;
        @(negedge clk);
        bus3.row_valid = 1'b0;
    endtask

    // Called at a negedge in FULL; returns at the negedge after the done pulse.
    task automatic stream3(input string tag, input logic [23:0] exp_t [7]);
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            chk($sformatf("%s_lane_t%0d", tag, t), 32'(bus3.lane_out), 32'(exp_t[t]));
            chk($sformatf("%s_en_t%0d", tag, t), 32'(bus3.en_out), 32'd1);
            chk($sformatf("%s_done_t%0d", tag, t), 32'(bus3.done), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(bus3.done), 32'd1);
        chk({tag, "_en_off"}, 32'(bus3.en_out), 32'd0);
        chk({tag, "_lane_off"}, 32'(bus3.lane_out), 32'd0);
        chk({tag, "_ready_at_done"}, 32'(bus3.row_ready), 32'd1);
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(bus3.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int en_cnt;
        int done_cnt;
        bus3.row_valid = 1'b0;
        bus3.row_data  = '0;
        bus3.start     = 1'b0;
        bus2.row_valid = 1'b0;
        bus2.row_data  = '0;
        bus2.start     = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus3.row_ready), 32'd0);
        chk("rst_lane", 32'(bus3.lane_out), 32'd0);
        chk("rst_en", 32'(bus3.en_out), 32'd0);
        chk("rst_busy", 32'(bus3.busy), 32'd0);
        chk("rst_done", 32'(bus3.done), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(bus3.row_ready), 32'd1);
        @(negedge clk);

        // Basic 3x3 tile
        load3(24'h030201);
        chk("t1_ready_load", 32'(bus3.row_ready), 32'd1);
        load3(24'h060504);
        load3(24'h090807);
        chk("t1_ready_full", 32'(bus3.row_ready), 32'd0);
        chk("t1_busy_full", 32'(bus3.busy), 32'd0);
        stream3("t1", exp_a);

        // Partial tile ignores start
        load3(24'h0C0B0A);
        load3(24'h0F0E0D);
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        @(negedge clk);
        chk("t2_en", 32'(bus3.en_out), 32'd0);
        chk("t2_ready", 32'(bus3.row_ready), 32'd1);
        chk("t2_state", 32'(dut3.state_q), 32'(StLoad));
        load3(24'h121110);
        chk("t2_full_ready", 32'(bus3.row_ready), 32'd0);
        chk("t2_full_state", 32'(dut3.state_q), 32'(StFull));

        // start held for 5 cycles in FULL
        en_cnt   = 0;
        done_cnt = 0;
        bus3.start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 5) bus3.start = 1'b0;
            @(negedge clk);
            en_cnt   += int'(bus3.en_out);
            done_cnt += int'(bus3.done);
        end
        chk("t6_en_cycles", 32'(en_cnt), 32'd7);
        chk("t6_done_pulses", 32'(done_cnt), 32'd1);
        chk("t6_state", 32'(dut3.state_q), 32'(StIdle));

        // Back-to-back rows with row_valid held high
        bus3.row_valid = 1'b1;
        bus3.row_data  = 24'h232221;
        @(negedge clk);
        bus3.row_data  = 24'h333231;
        @(negedge clk);
        bus3.row_data  = 24'h434241;
        @(negedge clk);
        chk("t4_ready_full", 32'(bus3.row_ready), 32'd0);
        bus3.row_data  = 24'h000099;
        @(negedge clk);
        chk("t4_hold_ready", 32'(bus3.row_ready), 32'd0);
        chk("t4_hold_state", 32'(dut3.state_q), 32'(StFull));
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            chk($sformatf("t4_lane_t%0d", t), 32'(bus3.lane_out), 32'(exp_b[t]));
            chk($sformatf("t4_ready_t%0d", t), 32'(bus3.row_ready), 32'd0);
            bus3.start = (t == 2);
            @(negedge clk);
        end
        chk("t4_done", 32'(bus3.done), 32'd1);
        chk("t4_ready_done", 32'(bus3.row_ready), 32'd1);
        @(negedge clk);
        bus3.row_valid = 1'b0;
        chk("t4_extra_state", 32'(dut3.state_q), 32'(StLoad));
        chk("t4_no_extend", 32'(bus3.en_out), 32'd0);

        // Reset during stream cycle t=2
        load3(24'h333231);
        load3(24'h434241);
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_en_before", 32'(bus3.en_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_lane", 32'(bus3.lane_out), 32'd0);
        chk("t5_en", 32'(bus3.en_out), 32'd0);
        chk("t5_busy", 32'(bus3.busy), 32'd0);
        chk("t5_ready", 32'(bus3.row_ready), 32'd0);
        @(negedge clk);
        chk("t5_done_rst", 32'(bus3.done), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t5_ready_rel", 32'(bus3.row_ready), 32'd1);
        @(negedge clk);
        chk("t5_done_rel", 32'(bus3.done), 32'd0);
        load3(24'h030201);
        load3(24'h060504);
        load3(24'h090807);
        stream3("t5", exp_a);

        // Signed extremes on the DIM=2 instance
        bus2.row_valid = 1'b1;
        bus2.row_data  = 16'h7F80;
        @(negedge clk);
        bus2.row_data  = 16'h00FF;
        @(negedge clk);
        bus2.row_valid = 1'b0;
        chk("t3_ready_full", 32'(bus2.row_ready), 32'd0);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("t3_lane_t%0d", t), 32'(bus2.lane_out), 32'(exp_s[t]));
            chk($sformatf("t3_en_t%0d", t), 32'(bus2.en_out), 32'd1);
            @(negedge clk);
        end
        chk("t3_done", 32'(bus2.done), 32'd1);
        chk("t3_en_off", 32'(bus2.en_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
